// File: rtl/data_mem_responder_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
package dmem_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Zero-extension does not change the XOR reduction, so one width fits all.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between CPU and memory.
interface data_mem_responder_if import dmem_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_array.sv
// dmem_array: single-port RAM, synchronous write-first read with one cycle latency.
module dmem_array import dmem_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WIDTH  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_W];

    // A store returns the written word, which gives the response echo for free.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= we ? wdata : mem[addr];
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated load/store responder over valid/ready handshakes.
// Optional DMEM_PARITY_EN stores an even-parity bit per word and flags load mismatches.
module data_mem_responder import dmem_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus,
    output logic                 busy
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef DMEM_PARITY_EN
    localparam int WW = DATA_W + 1;
`else
    localparam int WW = DATA_W;
`endif

    state_e            state;
    logic [CW-1:0]     cnt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              access;
    logic [WW-1:0]     ram_wdata;
    logic [WW-1:0]     ram_rdata;

    assign access = (state == ST_WAIT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    state   <= ST_WAIT;
                    cnt     <= CW'(WAIT_CYCLES);
                    write_q <= bus.req_write;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                end
                ST_WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
                         else state <= ST_RESP;
                ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMEM_PARITY_EN
    assign ram_wdata   = {even_parity(64'(wdata_q)), wdata_q};
    assign bus.rsp_err = bus.rsp_valid && !write_q &&
                         (ram_rdata[DATA_W] != even_parity(64'(ram_rdata[DATA_W-1:0])));
`else
    assign ram_wdata   = wdata_q;
    assign bus.rsp_err = 1'b0;
`endif

    dmem_array #(.ADDR_W(ADDR_W), .WIDTH(WW)) u_array (
        .clk   (clk),
        .en    (access),
        .we    (write_q),
        .addr  (addr_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign busy          = (state != ST_IDLE);
    // RAM output register is not reset, so gate it to give a clean zero outside RESP.
    assign bus.rsp_rdata = bus.rsp_valid ? ram_rdata[DATA_W-1:0] : '0;
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU's data-memory port. It accepts one load or store request at a time over a valid/ready handshake, inserts a fixed number of wait states, and performs the access on an internal 256×8 array. It then returns a response over a second valid/ready handshake. The CPU's memory-access state drives the request side; this block replaces the direct-strobe data memory.

## Interface
- `ADDR_W`, 8: address width; the array depth is 2**ADDR_W words.
- `DATA_W`, 8: data word width.
- `WAIT_CYCLES`, 2: wait states between request acceptance and the access; legal range 0..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous reset, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  ADDR_W: word address.
- `req_wdata`  in  DATA_W: store data.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: CPU takes the response.
- `rsp_rdata`  out  DATA_W: load data; for a store, echoes the stored word.
- `rsp_err`  out  1: parity error on a load; constant 0 without the parity macro.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: wait-state countdown.
  - RESP: `rsp_valid`=1.
- IDLE→WAIT on `req_valid & req_ready`:
  - capture `req_write`, `req_addr` and `req_wdata` into internal registers;
  - load the wait counter with WAIT_CYCLES.
- WAIT with counter ≠ 0: decrement; stay in WAIT.
- WAIT with counter = 0: perform the access using the captured request, then go to RESP.
  - Store: write the array; `rsp_rdata` ← captured wdata.
  - Load: `rsp_rdata` ← array[addr].
- RESP→IDLE on `rsp_valid & rsp_ready`.
- RESP is held indefinitely while `rsp_ready`=0. `rsp_rdata` and `rsp_err` stay stable while held.
- Input changes after acceptance have no effect. `req_valid` outside IDLE is ignored.
- Counter width is max(1, $clog2(WAIT_CYCLES+1)), unsigned. The counter never wraps because the decrement happens only when it is non-zero.
- Address covers the full array; there is no out-of-range case.
- Reset (asserted at any time):
  - state → IDLE; `rsp_valid`=0, `busy`=0, `req_ready`=1 after release; `rsp_rdata`=0, `rsp_err`=0, counter=0.
  - Array contents are not reset.
  - A store accepted but still in WAIT is dropped and the array is unchanged.
  - A store already committed on the WAIT→RESP edge remains in the array.

## Timing
- Acceptance at edge E0 → `rsp_valid` high after edge E0+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: response one cycle after acceptance.
- Response handshake at edge E1 → `req_ready` high after E1. The next request can be accepted at edge E1+1.
- Minimum throughput: one transaction per WAIT_CYCLES+3 cycles.
- Outputs are registered or decoded from the state register only. There are no combinational paths from `req_*` or `rsp_ready` to any output.
- The array has synchronous write and synchronous read with 1-cycle read latency. The read is issued on the last WAIT cycle so the data lands in RESP.

## Configuration
- Macro: `DMEM_PARITY_EN`.
- Defined:
  - each array word stores DATA_W+1 bits (data plus even parity computed at store time);
  - a load recomputes parity and sets `rsp_err`=1 on mismatch;
  - a store response has `rsp_err`=0.
- Undefined: no parity bit is stored and `rsp_err` is tied to 0.
- Handshake timing is identical in both builds.

## Structure
- Package `dmem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - default ADDR_W/DATA_W constants;
  - the even-parity function.
- One sub-module, `dmem_array`: parameterized single-port RAM (we, addr, wdata, rdata) with synchronous read. Word width is DATA_W+1 when `DMEM_PARITY_EN` is defined.
- Top level holds the FSM, wait counter, request capture registers and response registers.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `req_ready`=1, `rsp_valid`=0, `busy`=0, `rsp_rdata`=0x00 immediately, without waiting for a clock edge.
- Store then load:
  - WAIT_CYCLES=2: store 0xA5 to 0x3C → `rsp_valid` 3 cycles after acceptance, `rsp_rdata`=0xA5.
  - Then load 0x3C → `rsp_rdata`=0xA5, `rsp_err`=0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during a load of 0x10 (contents 0x5E) → `rsp_valid` and `rsp_rdata`=0x5E stable all 5 cycles; IDLE one cycle after `rsp_ready`=1.
- Busy ignore: while in WAIT, pulse `req_valid` with a store of 0xFF to 0x00 → `req_ready`=0, the array at 0x00 is unchanged and exactly one response is produced.
- Reset mid-store: accept a store of 0x77 to 0x20, then assert reset in the first WAIT cycle → array at 0x20 keeps its prior value (0x11).
- Parity (`DMEM_PARITY_EN`): store 0x0F to 0x44, flip data bit 0 through a hierarchical write to `dmem_array`, then load 0x44 → `rsp_rdata`=0x0E, `rsp_err`=1.
